ipf_stream_src: RTL and testbench
=================================

Name: ipf_stream_src

Overview:
- Host-side transmitter for the IPF pixel-input interface. It drives `in_en`/`din` and the per-LCU filter parameters that the IPF block consumes.
- It reads a 128x128 8-bit image from an external image memory and per-LCU parameter words from a parameter memory.
- It streams pixels gaplessly in LCU-raster order (LCUs raster by `lcu_y`/`lcu_x`; pixels raster by row/col inside each LCU).
- It honours the IPF `busy` back-pressure and reports completion.

Parameters:
- IMG_W, 128, image width and height in pixels (power of 2).
- ADDR_W, 14, image address width (log2 of IMG_W*IMG_W).
- PAR_W, 24, parameter word width: {ipf_type[1:0], band_pos[4:0], wo_class, offset[15:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a frame when idle or done.
- lcu_size_cfg  in  2  0=16, 1=32, 2 or 3=64; latched at start.
- img_rd_en  out  1  image read strobe.
- img_rd_addr  out  14  image read address.
- img_rd_data  in  8  read data; valid 1 cycle after img_rd_en.
- par_rd_addr  out  6  LCU index for the parameter read.
- par_rd_data  in  24  parameter word; valid 1 cycle after par_rd_addr is driven.
- busy  in  1  IPF back-pressure.
- in_en  out  1  din valid.
- din  out  8  pixel.
- ipf_type  out  2  filter type for the current LCU.
- ipf_band_pos  out  5  band position for the current LCU.
- ipf_wo_class  out  1  WO class for the current LCU.
- ipf_offset  out  16  offsets for the current LCU.
- lcu_x  out  3  current LCU column.
- lcu_y  out  3  current LCU row.
- lcu_size  out  2  latched size code (3 is mapped to 2).
- done  out  1  frame complete.

Behaviour:
- **Reset:** the cycle after reset is sampled high, all outputs are 0, FSM is IDLE and counters are 0. Reset mid-frame aborts the frame immediately; the in-flight read is discarded.
- **FSM states:** IDLE, FETCH0, LOAD0, STREAM, DRAIN, DONE.
  - IDLE: on start, go to FETCH0; latch size; LCU index=0.
  - FETCH0: drive par_rd_addr=0.
  - LCU0 parameter load: in LCU0 the parameter shadow register captures par_rd_data; the FSM then enters STREAM.
  - STREAM: issues reads for the frame; after the read of the final pixel of the final LCU is issued, go to DRAIN.
  - DRAIN: the last pixel is presented; next state is DONE.
  - DONE: done=1 and held; start returns to FETCH0 with a fresh latch.
  - start is ignored in FETCH0, LCU0 parameter load, STREAM and DRAIN.
- **Geometry:** S = 16/32/64 and LCUs per side = 8/4/2, giving 64/16/4 LCUs. LCU index = lcu_y*(128/S) + lcu_x.
- **Address:** img_rd_addr = {lcu_y, row, lcu_x, col}, with fields 3/4/3/4, 2/5/2/5 or 1/6/1/6 bits for size codes 0/1/2.
- **Read issue:** in STREAM, a read is issued in each cycle with busy=0, and the col/row/lcu counters advance. When busy=1, no read is issued and counters hold. col wraps at S-1 into row; row wraps at S-1 into the next LCU.
- **Latency:** data is registered to din with in_en=1 exactly 1 cycle after its read.
  - When busy rises, at most one further in_en (the in-flight read) follows.
  - No pixel is dropped or duplicated.
  - With busy=0 throughout, in_en is continuous from the first pixel to the last (no inter-LCU bubbles).
- **Parameter prefetch:**
  - In the cycle the pixel-0 read of LCU k is issued, the parameter outputs are loaded from the shadow register, so they change in the same cycle in_en carries pixel 0 of LCU k.
  - lcu_x/lcu_y also update at that edge.
  - In the same cycle par_rd_addr=k+1 is driven; the shadow captures it on the next cycle.
  - No prefetch is made past the final LCU.
- **Parameter stability:** parameter outputs are stable from pixel 0 through pixel S*S-1 of each LCU.
- **done timing:** done rises the cycle after the final in_en.

Decomposition:
- Shared package ipf_pkg holds:
  - lcu size codes and S/LCU-count lookup;
  - PAR_W field offsets;
  - IMG_W and ADDR_W;
  - the FSM state enum.
- Sub-module ipf_addr_gen holds the col/row/lcu_x/lcu_y counters with an advance enable. It outputs the size-muxed address plus lcu_first and frame_last flags.

Test Plan:
1. size 0, busy=0 -> read 16 at addr 15, read 17 at addr 128, read 257 at addr 16 (lcu_x=1); 16384 contiguous in_en; done 1 cycle after the last.
2. size 2 -> (lcu_x,lcu_y) sequence (0,0),(1,0),(0,1),(1,1); read 4097 at addr 64; read 8193 at addr 8192.
3. par mem[k]={k%3,k[4:0],k[0],16'hA5k} with size 1 -> ipf_type changes exactly on the in_en cycle of pixel 0 of each LCU; in_en never drops between LCUs.
4. busy high 5 cycles mid-LCU -> exactly 1 in_en after busy rises, then none; resume at the next address; din sequence matches memory with no gaps or repeats.
5. reset asserted at pixel 3000 -> next cycle in_en=0, done=0, img_rd_en=0; a later start restarts at addr 0 with par_rd_addr=0.
6. start pulsed during STREAM -> no effect; start in DONE -> new frame, done clears next cycle.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF pixel-input source: image geometry,
// LCU size codes and lookups, parameter word layout and FSM states.
package ipf_pkg;

  localparam int IMG_W     = 128;
  localparam int ADDR_W    = 14;
  localparam int PAR_W     = 24;
  localparam int LCU_IDX_W = 6;

  // Parameter word layout: {ipf_type[1:0], band_pos[4:0], wo_class, offset[15:0]}
  localparam int PAR_OFFSET_LSB = 0;
  localparam int PAR_OFFSET_W   = 16;
  localparam int PAR_WO_BIT     = 16;
  localparam int PAR_BAND_LSB   = 17;
  localparam int PAR_BAND_W     = 5;
  localparam int PAR_TYPE_LSB   = 22;
  localparam int PAR_TYPE_W     = 2;

  typedef enum logic [1:0] {
    LCU_16 = 2'd0,
    LCU_32 = 2'd1,
    LCU_64 = 2'd2
  } lcu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_LOAD0,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Size codes 2 and 3 both select 64x64 LCUs.
  function automatic lcu_size_e norm_size(input logic [1:0] cfg);
    case (cfg)
      2'd0:    return LCU_16;
      2'd1:    return LCU_32;
      default: return LCU_64;
    endcase
  endfunction

  // LCU side length minus one (S-1).
  function automatic logic [5:0] lcu_side_m1(input lcu_size_e sz);
    case (sz)
      LCU_16:  return 6'd15;
      LCU_32:  return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

  // LCUs per image side minus one (IMG_W/S - 1).
  function automatic logic [2:0] lcu_per_side_m1(input lcu_size_e sz);
    case (sz)
      LCU_16:  return 3'd7;
      LCU_32:  return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ipf_addr_gen.sv
// Pixel position counters (col, row, lcu_x, lcu_y) walking the image in
// LCU-raster order, with the size-dependent image address and LCU flags.
module ipf_addr_gen
  import ipf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  lcu_size_e            size,
  input  logic                 clear,
  input  logic                 adv,
  output logic [ADDR_W-1:0]    addr,
  output logic [2:0]           lcu_x,
  output logic [2:0]           lcu_y,
  output logic [LCU_IDX_W-1:0] lcu_idx,
  output logic                 lcu_first,
  output logic                 lcu_last,
  output logic                 frame_last
);

  logic [5:0] col;
  logic [5:0] row;
  logic       col_end;
  logic       row_end;
  logic       x_end;
  logic       y_end;

  assign col_end    = (col == lcu_side_m1(size));
  assign row_end    = (row == lcu_side_m1(size));
  assign x_end      = (lcu_x == lcu_per_side_m1(size));
  assign y_end      = (lcu_y == lcu_per_side_m1(size));
  assign lcu_first  = (col == 6'd0) && (row == 6'd0);
  assign lcu_last   = x_end && y_end;
  assign frame_last = col_end && row_end && lcu_last;

  // Advance col -> row -> lcu_x -> lcu_y by one pixel per enabled cycle.
  // NOTE: state is updated with non-blocking assignments so every counter
  // sees the pre-edge values of the others within the same clock edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col   <= '0;
      row   <= '0;
      lcu_x <= '0;
      lcu_y <= '0;
    end else if (adv) begin
      if (!col_end) begin
        col <= col + 6'd1;
      end else begin
        col <= '0;
        if (!row_end) begin
          row <= row + 6'd1;
        end else begin
          row <= '0;
          if (!x_end) begin
            lcu_x <= lcu_x + 3'd1;
          end else begin
            lcu_x <= '0;
            lcu_y <= y_end ? 3'd0 : lcu_y + 3'd1;
          end
        end
      end
    end
  end

  // Pack {lcu_y, row, lcu_x, col} with field widths set by the LCU size.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    addr    = '0;
    lcu_idx = '0;
    case (size)
      LCU_16: begin
        addr    = {lcu_y, row[3:0], lcu_x, col[3:0]};
        lcu_idx = {lcu_y, lcu_x};
      end
      LCU_32: begin
        addr    = {lcu_y[1:0], row[4:0], lcu_x[1:0], col[4:0]};
        lcu_idx = {2'b00, lcu_y[1:0], lcu_x[1:0]};
      end
      default: begin
        addr    = {lcu_y[0], row, lcu_x[0], col};
        lcu_idx = {4'b0000, lcu_y[0], lcu_x[0]};
      end
    endcase
  end

endmodule

// File: rtl/ipf_stream_src.sv
// Host-side IPF pixel source: reads the image in LCU-raster order, streams
// pixels to the IPF with back-pressure, and prefetches per-LCU parameters.
module ipf_stream_src
  import ipf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           lcu_size_cfg,
  output logic                 img_rd_en,
  output logic [ADDR_W-1:0]    img_rd_addr,
  input  logic [7:0]           img_rd_data,
  output logic [LCU_IDX_W-1:0] par_rd_addr,
  input  logic [PAR_W-1:0]     par_rd_data,
  input  logic                 busy,
  output logic                 in_en,
  output logic [7:0]           din,
  output logic [1:0]           ipf_type,
  output logic [4:0]           ipf_band_pos,
  output logic                 ipf_wo_class,
  output logic [15:0]          ipf_offset,
  output logic [2:0]           lcu_x,
  output logic [2:0]           lcu_y,
  output logic [1:0]           lcu_size,
  output logic                 done
);

  state_e                 state;
  lcu_size_e              size_q;
  logic                   rd_vld_q;
  logic                   par_req_q;
  logic                   par_cap_q;
  logic [PAR_W-1:0]       shadow_q;
  logic [PAR_W-1:0]       par_q;
  logic                   issue;
  logic                   frame_start;
  logic [ADDR_W-1:0]      ag_addr;
  logic [2:0]             ag_lcu_x;
  logic [2:0]             ag_lcu_y;
  logic [LCU_IDX_W-1:0]   ag_lcu_idx;
  logic                   ag_lcu_first;
  logic                   ag_lcu_last;
  logic                   ag_frame_last;

  assign frame_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign issue       = (state == ST_STREAM) && !busy;

  assign img_rd_en   = issue;
  assign img_rd_addr = ag_addr;

  // Image memory returns data one cycle after the strobe; rd_vld_q marks it.
  assign in_en = rd_vld_q;
  assign din   = rd_vld_q ? img_rd_data : 8'd0;

  assign ipf_type     = par_q[PAR_TYPE_LSB +: PAR_TYPE_W];
  assign ipf_band_pos = par_q[PAR_BAND_LSB +: PAR_BAND_W];
  assign ipf_wo_class = par_q[PAR_WO_BIT];
  assign ipf_offset   = par_q[PAR_OFFSET_LSB +: PAR_OFFSET_W];
  assign lcu_size     = size_q;

  ipf_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .size       (size_q),
    .clear      (frame_start),
    .adv        (issue),
    .addr       (ag_addr),
    .lcu_x      (ag_lcu_x),
    .lcu_y      (ag_lcu_y),
    .lcu_idx    (ag_lcu_idx),
    .lcu_first  (ag_lcu_first),
    .lcu_last   (ag_lcu_last),
    .frame_last (ag_frame_last)
  );

  // Frame control FSM plus parameter prefetch/shadow and the read-valid pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      size_q    <= LCU_16;
      rd_vld_q  <= 1'b0;
      par_req_q <= 1'b0;
      par_cap_q <= 1'b0;
      shadow_q  <= '0;
      par_q     <= '0;
      par_rd_addr <= '0;
      lcu_x     <= '0;
      lcu_y     <= '0;
      done      <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      // Prefetched word is valid one cycle after its address is driven.
      par_req_q <= 1'b0;
      par_cap_q <= par_req_q;
      if (par_cap_q) shadow_q <= par_rd_data;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_FETCH0;
            size_q      <= norm_size(lcu_size_cfg);
            par_rd_addr <= '0;
            done        <= 1'b0;
          end
        end
        ST_FETCH0: state <= ST_LOAD0;
        ST_LOAD0: begin
          shadow_q <= par_rd_data;
          state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (issue) begin
            if (ag_lcu_first) begin
              // Outputs switch as pixel 0 of this LCU is read, so they
              // line up with its in_en cycle; then fetch the next LCU's word.
              par_q <= shadow_q;
              lcu_x <= ag_lcu_x;
              lcu_y <= ag_lcu_y;
              if (!ag_lcu_last) begin
                par_rd_addr <= ag_lcu_idx + 6'd1;
                par_req_q   <= 1'b1;
              end
            end
            if (ag_frame_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipf_stream_src.sv
// Directed bench for ipf_stream_src: behavioural image/parameter memories,
// a negedge monitor that logs reads and checks every streamed pixel against
// an independent LCU-raster model, and a linear sequence of directed steps.
module tb_ipf_stream_src;

  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  lcu_size_cfg;
  logic        img_rd_en;
  logic [13:0] img_rd_addr;
  logic [7:0]  img_rd_data;
  logic [5:0]  par_rd_addr;
  logic [23:0] par_rd_data;
  logic        busy;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x;
  logic [2:0]  lcu_y;
  logic [1:0]  lcu_size;
  logic        done;

  ipf_stream_src dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .lcu_size_cfg (lcu_size_cfg),
    .img_rd_en    (img_rd_en),
    .img_rd_addr  (img_rd_addr),
    .img_rd_data  (img_rd_data),
    .par_rd_addr  (par_rd_addr),
    .par_rd_data  (par_rd_data),
    .busy         (busy),
    .in_en        (in_en),
    .din          (din),
    .ipf_type     (ipf_type),
    .ipf_band_pos (ipf_band_pos),
    .ipf_wo_class (ipf_wo_class),
    .ipf_offset   (ipf_offset),
    .lcu_x        (lcu_x),
    .lcu_y        (lcu_y),
    .lcu_size     (lcu_size),
    .done         (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int side(input int sz);
    return 16 << sz;
  endfunction

  function automatic int nper(input int sz);
    return 8 >> sz;
  endfunction

  function automatic int exp_lcu(input int sz, input int n);
    return n / (side(sz) * side(sz));
  endfunction

  // Natural image address of the n-th pixel in LCU-raster order.
  function automatic int exp_addr(input int sz, input int n);
    int s, np, k, p;
    s  = side(sz);
    np = nper(sz);
    k  = exp_lcu(sz, n);
    p  = n % (s * s);
    return ((k / np) * s + p / s) * 128 + (k % np) * s + p % s;
  endfunction

  function automatic logic [5:0] exp_pos(input int sz, input int n);
    int k, np;
    k  = exp_lcu(sz, n);
    np = nper(sz);
    return {3'(k / np), 3'(k % np)};
  endfunction

  function automatic logic [7:0] pix_val(input int a);
    logic [13:0] av;
    av = 14'(a);
    return av[7:0] ^ {2'b00, av[13:8]} ^ 8'h5A;
  endfunction

  function automatic logic [23:0] par_word(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {2'(k % 3), kb[4:0], kb[0], 8'hA5, kb};
  endfunction

  // ---------------- memories ----------------
  always @(posedge clk) begin
    if (img_rd_en) img_rd_data <= pix_val(int'(img_rd_addr));
    par_rd_data <= par_word(int'(par_rd_addr));
  end

  // ---------------- monitor ----------------
  logic        mon_clr;
  int          mon_sz;
  int          cyc = 0;
  int          rd_cnt, in_cnt, din_err, par_err, pos_err, gaps, done_rises;
  int          done_cyc, first_in_cyc, last_in_cyc, start_cyc;
  int          busy_en_cnt, busy_rd_cnt;
  logic        prev_in_en = 1'b0;
  logic        prev_done = 1'b0;
  logic [13:0] rd_log [NPIX];
  logic [5:0]  pos_log [64];

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_in_en <= in_en;
    prev_done  <= done;
    if (mon_clr) begin
      rd_cnt       <= 0;
      in_cnt       <= 0;
      din_err      <= 0;
      par_err      <= 0;
      pos_err      <= 0;
      gaps         <= 0;
      done_rises   <= 0;
      done_cyc     <= -1;
      first_in_cyc <= -1;
      last_in_cyc  <= -1;
      start_cyc    <= -1;
      busy_en_cnt  <= 0;
      busy_rd_cnt  <= 0;
    end else begin
      if (img_rd_en) begin
        if (rd_cnt < NPIX) rd_log[rd_cnt] <= img_rd_addr;
        rd_cnt <= rd_cnt + 1;
      end
      if (in_en) begin
        if (din !== pix_val(exp_addr(mon_sz, in_cnt))) din_err <= din_err + 1;
        if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== par_word(exp_lcu(mon_sz, in_cnt)))
          par_err <= par_err + 1;
        if ({lcu_y, lcu_x} !== exp_pos(mon_sz, in_cnt)) pos_err <= pos_err + 1;
        if ((in_cnt % (side(mon_sz) * side(mon_sz)) == 0) && (exp_lcu(mon_sz, in_cnt) < 64))
          pos_log[exp_lcu(mon_sz, in_cnt)] <= {lcu_y, lcu_x};
        if (in_cnt == 0) first_in_cyc <= cyc;
        if (!prev_in_en && in_cnt != 0) gaps <= gaps + 1;
        last_in_cyc <= cyc;
        in_cnt      <= in_cnt + 1;
      end
      if (done && !prev_done) begin
        done_rises <= done_rises + 1;
        done_cyc   <= cyc;
      end
      if (busy && in_en) busy_en_cnt <= busy_en_cnt + 1;
      if (busy && img_rd_en) busy_rd_cnt <= busy_rd_cnt + 1;
      if (start && start_cyc < 0) start_cyc <= cyc;
    end
  end

  // ---------------- checking and stimulus helpers ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int cfg);
    lcu_size_cfg = 2'(cfg);
    mon_sz       = (cfg > 2) ? 2 : cfg;
    mon_clr      = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_done_reached"}, 32'(done), 32'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pixels(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (in_cnt < n && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_pixels_reached"}, 32'(in_cnt >= n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int saved_cnt;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    busy         = 1'b0;
    lcu_size_cfg = 2'd0;
    mon_clr      = 1'b1;
    mon_sz       = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'({in_en, done, img_rd_en, lcu_size, lcu_x, lcu_y, par_rd_addr, img_rd_addr}), 32'd0);
    check("reset_data", {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Size 0 frame, no back-pressure
    start_frame(0);
    wait_done(20000, "t1");
    check("t1_rd_count",      32'(rd_cnt), 32'd16384);
    check("t1_rd16_addr",     32'(rd_log[15]), 32'd15);
    check("t1_rd17_addr",     32'(rd_log[16]), 32'd128);
    check("t1_rd257_addr",    32'(rd_log[256]), 32'd16);
    check("t1_in_count",      32'(in_cnt), 32'd16384);
    check("t1_gaps",          32'(gaps), 32'd0);
    check("t1_din_seq",       32'(din_err), 32'd0);
    check("t1_params",        32'(par_err), 32'd0);
    check("t1_lcu_pos",       32'(pos_err), 32'd0);
    check("t1_first_latency", 32'(first_in_cyc - start_cyc), 32'd4);
    check("t1_done_timing",   32'(done_cyc - last_in_cyc), 32'd1);
    check("t1_lcu_size",      32'(lcu_size), 32'd0);

    // Size code 3 (64x64) frame with a 5-cycle busy burst inside LCU 0
    start_frame(3);
    wait_pixels(1000, 3000, "t4");
    busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 busy = 1'b0;
    wait_done(20000, "t2");
    check("t2_lcu_size",      32'(lcu_size), 32'd2);
    check("t2_pos_lcu0",      32'(pos_log[0]), 32'd0);
    check("t2_pos_lcu1",      32'(pos_log[1]), 32'd1);
    check("t2_pos_lcu2",      32'(pos_log[2]), 32'd8);
    check("t2_pos_lcu3",      32'(pos_log[3]), 32'd9);
    check("t2_rd4097_addr",   32'(rd_log[4096]), 32'd64);
    check("t2_rd8193_addr",   32'(rd_log[8192]), 32'd8192);
    check("t2_rd_count",      32'(rd_cnt), 32'd16384);
    check("t2_in_count",      32'(in_cnt), 32'd16384);
    check("t4_in_en_in_busy", 32'(busy_en_cnt), 32'd1);
    check("t4_rd_in_busy",    32'(busy_rd_cnt), 32'd0);
    check("t4_gaps",          32'(gaps), 32'd1);
    check("t4_din_seq",       32'(din_err), 32'd0);
    check("t2_params",        32'(par_err), 32'd0);

    // Size 1 frame; start (with a different size) pulsed mid-stream
    start_frame(1);
    wait_pixels(500, 2000, "t6a");
    lcu_size_cfg = 2'd0;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20000, "t3");
    check("t6_size_kept",     32'(lcu_size), 32'd1);
    check("t3_in_count",      32'(in_cnt), 32'd16384);
    check("t3_gaps",          32'(gaps), 32'd0);
    check("t3_params",        32'(par_err), 32'd0);
    check("t3_lcu_pos",       32'(pos_err), 32'd0);
    check("t3_din_seq",       32'(din_err), 32'd0);
    check("t3_done_rises",    32'(done_rises), 32'd1);
    check("t3_done_timing",   32'(done_cyc - last_in_cyc), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_done_held",     32'(done), 32'd1);

    // start in DONE launches a new size 0 frame
    start_frame(0);
    check("t6_done_clear",    32'(done), 32'd0);
    check("t6_relatch",       32'(lcu_size), 32'd0);

    // Reset mid-frame at pixel 3000
    wait_pixels(3000, 5000, "t5");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_reset_quiet",   32'({in_en, done, img_rd_en}), 32'd0);
    saved_cnt = in_cnt;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_pix_after_reset", 32'(in_cnt), 32'(saved_cnt));

    start_frame(0);
    check("t5_fetch0_par_addr", 32'(par_rd_addr), 32'd0);
    wait_pixels(300, 400, "t5r");
    check("t5_restart_addr0",   32'(rd_log[0]), 32'd0);
    check("t5_restart_rd257",   32'(rd_log[256]), 32'd16);
    check("t5_restart_latency", 32'(first_in_cyc - start_cyc), 32'd4);
    check("t5_restart_din",     32'(din_err), 32'd0);
    check("t5_restart_params",  32'(par_err), 32'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
